// File: rtl/hht_pkg.sv
// Shared types and defaults for the HHT fetch scheduler: control state encoding
// and the default run geometry.
package hht_pkg;

    localparam int V_SIZE_DEF = 9;
    localparam int DW_DEF     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_V,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hht_out_stage.sv
// Single-entry column output register with valid/ready holding; reports when
// a new word may be loaded this cycle.
module hht_out_stage #(
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          col_ready,
    output logic          col_valid,
    output logic [DW-1:0] col_data,
    output logic          can_load
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // A word may enter when the register is empty or its occupant leaves this cycle.
    assign can_load  = !valid_q || col_ready;
    assign col_valid = valid_q;
    assign col_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (col_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/hht_fetch_sched.sv
// HHT fetch scheduler: loads V_SIZE v-values from memory, then streams csize
// column words through a valid/ready output register over one shared read port.
module hht_fetch_sched
    import hht_pkg::*;
#(
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DW-1:0]        v_values_base,
    input  logic [DW-1:0]        wdata_col_base,
    input  logic [DW-1:0]        csize,
    output logic [DW-1:0]        mem_addr,
    output logic                 mem_rd,
    input  logic [DW-1:0]        mem_rdata,
    output logic [V_SIZE*DW-1:0] val,
    output logic                 col_valid,
    output logic [DW-1:0]        col_data,
    input  logic                 col_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int KW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(V_SIZE - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] v_idx_q, v_idx_d;
    logic [DW-1:0] col_idx_q, col_idx_d;
    logic [DW-1:0] v_base_q, v_base_d;
    logic [DW-1:0] col_base_q, col_base_d;
    logic [DW-1:0] csize_q, csize_d;
    logic [DW-1:0] val_q [V_SIZE];
    logic [DW-1:0] val_d [V_SIZE];

    logic issue;
    logic can_load;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        v_idx_d    = v_idx_q;
        col_idx_d  = col_idx_q;
        v_base_d   = v_base_q;
        col_base_d = col_base_q;
        csize_d    = csize_q;
        val_d      = val_q;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        issue      = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD_V;
                    v_idx_d    = '0;
                    col_idx_d  = '0;
                    v_base_d   = v_values_base;
                    col_base_d = wdata_col_base;
                    csize_d    = csize;
                end
            end
            ST_LOAD_V: begin
                mem_rd          = 1'b1;
                mem_addr        = v_base_q + DW'(v_idx_q);
                val_d[v_idx_q]  = mem_rdata;
                v_idx_d         = v_idx_q + KW'(1);
                if (v_idx_q == K_LAST) begin
                    state_d = (csize_q != '0) ? ST_STREAM : ST_DONE;
                end
            end
            ST_STREAM: begin
                // Reads are throttled by the output register so no word is ever overwritten.
                if (can_load) begin
                    issue     = 1'b1;
                    mem_rd    = 1'b1;
                    mem_addr  = col_base_q + col_idx_q;
                    col_idx_d = col_idx_q + DW'(1);
                    if (col_idx_q == csize_q - DW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (col_valid && col_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            v_idx_q    <= '0;
            col_idx_q  <= '0;
            v_base_q   <= '0;
            col_base_q <= '0;
            csize_q    <= '0;
            // NOTE: the v-value store is visible on a port and must read zero after reset, so it is cleared here.
            for (int i = 0; i < V_SIZE; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            v_idx_q    <= v_idx_d;
            col_idx_q  <= col_idx_d;
            v_base_q   <= v_base_d;
            col_base_q <= col_base_d;
            csize_q    <= csize_d;
            val_q      <= val_d;
        end
    end

    for (genvar g = 0; g < V_SIZE; g++) begin : g_val
        assign val[g*DW +: DW] = val_q[g];
    end

    hht_out_stage #(
        .DW(DW)
    ) u_out_stage (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (issue),
        .load_data (mem_rdata),
        .col_ready (col_ready),
        .col_valid (col_valid),
        .col_data  (col_data),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_hht_fetch_sched.sv
// Self-checking bench for hht_fetch_sched: directed runs plus randomized runs
// against a transaction-level model of the expected read and column sequences.
module tb_hht_fetch_sched;

    localparam int V  = 9;
    localparam int DW = 32;

    logic            Clk;
    logic            Rst;
    logic            start;
    logic [DW-1:0]   v_values_base;
    logic [DW-1:0]   wdata_col_base;
    logic [DW-1:0]   csize;
    logic [DW-1:0]   mem_addr;
    logic            mem_rd;
    logic [DW-1:0]   mem_rdata;
    logic [V*DW-1:0] val;
    logic            col_valid;
    logic [DW-1:0]   col_data;
    logic            col_ready;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_words[$];
    logic [31:0] got_addrs[$];

    hht_fetch_sched #(
        .V_SIZE(V),
        .DW    (DW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .start         (start),
        .v_values_base (v_values_base),
        .wdata_col_base(wdata_col_base),
        .csize         (csize),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .val           (val),
        .col_valid     (col_valid),
        .col_data      (col_data),
        .col_ready     (col_ready),
        .busy          (busy),
        .done          (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory image: the HHT reference contents at the directed addresses, a hash elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'd2:   mem_fn = 32'd78;
            32'd3:   mem_fn = 32'd59;
            32'd4:   mem_fn = 32'd60;
            32'd5:   mem_fn = 32'd62;
            32'd6:   mem_fn = 32'd1;
            32'd7:   mem_fn = 32'd35;
            32'd8:   mem_fn = 32'd40;
            32'd9:   mem_fn = 32'd43;
            32'd10:  mem_fn = 32'd63;
            32'd340: mem_fn = 32'd11;
            32'd341: mem_fn = 32'd2;
            32'd342: mem_fn = 32'd6;
            32'd343: mem_fn = 32'd24;
            32'd440: mem_fn = 32'd10;
            32'd441: mem_fn = 32'd24;
            default: mem_fn = (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // bp: 0 = always ready, 1 = five-cycle stall on word 3, 2 = random ready.
    task automatic run_check(input string tag, input logic [31:0] vb, input logic [31:0] cb,
                             input logic [31:0] cs, input int bp, input bit started, input bit hold,
                             input logic [31:0] nvb, input logic [31:0] ncb, input logic [31:0] ncs);
        logic [31:0]     exp_addrs[$];
        logic [V*32-1:0] exp_val;
        logic [31:0]     held;
        int cyc, done_cnt, done_cyc, budget, stall_cnt, n;
        int rd_viol, hold_viol, busy_viol, cv_seen;
        bit stalled, timed_out;

        cyc = 0; done_cnt = 0; done_cyc = -1; stall_cnt = 0;
        rd_viol = 0; hold_viol = 0; busy_viol = 0; cv_seen = 0;
        stalled = 1'b0; timed_out = 1'b0; held = '0;
        got_words.delete();
        got_addrs.delete();
        for (int k = 0; k < V; k++) begin
            exp_addrs.push_back(vb + 32'(k));
            exp_val[k*32 +: 32] = mem_fn(vb + 32'(k));
        end
        for (int j = 0; j < int'(cs); j++) begin
            exp_addrs.push_back(cb + 32'(j));
        end

        if (!started) begin
            @(negedge Clk);
            v_values_base  = vb;
            wdata_col_base = cb;
            csize          = cs;
            start          = 1'b1;
            col_ready      = 1'b1;
            @(posedge Clk);
        end
        budget = V + 4 * int'(cs) + 40;

        while (1) begin
            @(negedge Clk);
            cyc++;
            start          = hold;
            v_values_base  = nvb;
            wdata_col_base = ncb;
            csize          = ncs;
            case (bp)
                1: begin
                    col_ready = 1'b1;
                    if (col_valid && got_words.size() == 3 && stall_cnt < 5) begin
                        col_ready = 1'b0;
                        stall_cnt++;
                    end
                end
                2:       col_ready = ($urandom_range(0, 3) != 0);
                default: col_ready = 1'b1;
            endcase
            #1;
            if (!mem_rd && mem_addr !== '0) rd_viol++;
            if (mem_rd) got_addrs.push_back(mem_addr);
            if (stalled && (col_valid !== 1'b1 || col_data !== held)) hold_viol++;
            stalled = col_valid && !col_ready;
            held    = col_data;
            if (stalled && mem_rd) hold_viol++;
            if (col_valid) cv_seen++;
            if (col_valid && col_ready) got_words.push_back(col_data);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                if (busy !== 1'b0) busy_viol++;
                break;
            end
            if (busy !== 1'b1) busy_viol++;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge Clk);
        end
        @(posedge Clk);

        check({tag, " timeout"}, timed_out, 0);
        check({tag, " done pulses"}, done_cnt, 1);
        if (bp == 0) check({tag, " done cycle"}, done_cyc, V + ((cs != 0) ? int'(cs) + 2 : 1));
        if (bp == 1) check({tag, " stall cycles"}, stall_cnt, 5);
        check({tag, " read count"}, got_addrs.size(), exp_addrs.size());
        n = (got_addrs.size() < exp_addrs.size()) ? got_addrs.size() : exp_addrs.size();
        for (int i = 0; i < n; i++) check({tag, " read addr"}, got_addrs[i], exp_addrs[i]);
        check({tag, " word count"}, got_words.size(), int'(cs));
        n = (got_words.size() < int'(cs)) ? got_words.size() : int'(cs);
        for (int j = 0; j < n; j++) check({tag, " col word"}, got_words[j], mem_fn(cb + 32'(j)));
        check({tag, " val"}, val, exp_val);
        check({tag, " addr zero when idle"}, rd_viol, 0);
        check({tag, " hold under stall"}, hold_viol, 0);
        check({tag, " busy window"}, busy_viol, 0);
        if (cs == 0) check({tag, " col_valid cycles"}, cv_seen, 0);
    endtask

    initial begin
        int cnt;
        logic [31:0] rvb, rcb, rcs;

        Rst = 1'b1; start = 1'b0; col_ready = 1'b1;
        v_values_base = '0; wdata_col_base = '0; csize = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset outputs", {val, col_data, col_valid, mem_addr, mem_rd, busy, done}, 0);
        Rst = 1'b0;

        run_check("basic", 32'd2, 32'd340, 32'd102, 0, 0, 0, 32'h1234, 32'h5678, 32'd7);
        check("basic first word 0", got_words[0], 32'd11);
        check("basic first word 1", got_words[1], 32'd2);
        check("basic first word 2", got_words[2], 32'd6);
        check("basic first word 3", got_words[3], 32'd24);
        check("basic last word -2", got_words[100], 32'd10);
        check("basic last word -1", got_words[101], 32'd24);
        repeat (5) @(posedge Clk);
        #1;
        check("val retained", val,
              {32'd63, 32'd43, 32'd40, 32'd35, 32'd1, 32'd62, 32'd60, 32'd59, 32'd78});

        run_check("backpressure", 32'd2, 32'd340, 32'd12, 1, 0, 0, 32'hDEAD, 32'hBEEF, 32'd3);
        run_check("csize0", 32'd500, 32'd900, 32'd0, 0, 0, 0, 32'd1, 32'd2, 32'd3);

        @(negedge Clk);
        v_values_base = 32'd100; wdata_col_base = 32'd1000; csize = 32'd80;
        start = 1'b1; col_ready = 1'b1;
        @(posedge Clk);
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 50; c++) begin
            @(negedge Clk);
            start = 1'b0;
            #1;
            if (col_valid && col_ready) cnt++;
        end
        check("reach column 50", cnt, 50);
        Rst = 1'b1;
        #1;
        check("mid-run reset outputs", {val, col_data, col_valid, mem_addr, mem_rd, busy, done}, 0);
        @(posedge Clk);
        #1;
        check("reset held no done", {busy, done}, 0);
        #1;
        Rst = 1'b0;
        run_check("after reset", 32'd7, 32'd2000, 32'd15, 0, 0, 0, 32'd9, 32'd9, 32'd9);

        run_check("hold start", 32'd20, 32'd3000, 32'd6, 0, 0, 1, 32'd40, 32'd4000, 32'd4);
        run_check("restart", 32'd40, 32'd4000, 32'd4, 0, 1, 0, 32'd0, 32'd0, 32'd0);

        run_check("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'd5, 0, 0, 0, 32'd1, 32'd1, 32'd1);

        for (int r = 0; r < 6; r++) begin
            rvb = $urandom;
            rcb = $urandom;
            rcs = 32'($urandom_range(0, 20));
            run_check("random", rvb, rcb, rcs, 2, 0, 0, $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hht_fetch_sched.md
HHT_FETCH_SCHED -- requirements
Module: hht_fetch_sched

Interface
REQ-001 SHALL have parameter V_SIZE, default 9, number of v-values loaded per run.
REQ-002 SHALL have parameter DW, default 32, data and address width.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle run request; sampled only in IDLE.
REQ-006 SHALL have ports v_values_base, wdata_col_base and csize, each input, DW; captured on the accepted start.
REQ-007 SHALL have port mem_addr, output, DW, read address to the shared memory port.
REQ-008 SHALL have port mem_rd, output, 1, read strobe; asserted only for real accesses.
REQ-009 SHALL have port mem_rdata, input, DW, read data, combinationally valid in the same cycle as mem_addr.
REQ-010 SHALL have port val, output, V_SIZE*DW, loaded v-values; word k is in bits [k*DW +: DW].
REQ-011 SHALL have ports col_valid (output, 1), col_data (output, DW) and col_ready (input, 1), forming the column stream.
REQ-012 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-013 SHALL have port done, output, 1, one-cycle end-of-run pulse.

Function
REQ-014 SHALL implement states IDLE, LOAD_V, STREAM, DRAIN, DONE.
REQ-015 SHALL leave IDLE on start=1: go to LOAD_V and clear the v-index and column index.
REQ-016 SHALL, in LOAD_V, drive mem_addr=v_base+k and mem_rd=1 for k=0..V_SIZE-1, one per cycle, and write mem_rdata into val word k on that edge.
REQ-017 SHALL go from LOAD_V after k=V_SIZE-1 to STREAM if csize!=0, else to DONE; LOAD_V lasts exactly V_SIZE cycles.
REQ-018 SHALL, in STREAM, issue a read at col_base+j only when the output register is empty or being consumed this cycle (col_ready=1), then load col_data and set col_valid on the next edge.
REQ-019 SHALL give the column stream a latency of 1 cycle from address to col_valid, and sustain 1 word/cycle while col_ready=1.
REQ-020 SHALL hold col_valid and col_data stable while col_valid=1 and col_ready=0, and issue no read (mem_rd=0, j held) during that time.
REQ-021 SHALL leave STREAM for DRAIN after issuing j=csize-1.
REQ-022 SHALL, in DRAIN, wait until the last word is accepted (col_valid and col_ready both 1), then go to DONE.
REQ-023 SHALL, in DONE, assert done for one cycle, deassert busy on the next cycle, and return to IDLE.
REQ-024 SHALL ignore start outside IDLE, and SHALL NOT latch new base or size values mid-run.
REQ-025 SHALL wrap address additions modulo 2^DW; csize is treated as unsigned.
REQ-026 SHALL keep val unchanged after a run until the next LOAD_V overwrites it.
REQ-027 SHALL drive mem_addr=0 whenever mem_rd=0.

Reset
REQ-028 SHALL, on Rst=1 at any time including mid-run: enter IDLE; zero all of val, col_data, col_valid, mem_addr, mem_rd, busy, done and both indices; abandon the run, produce no done pulse, and drop a pending output word.
REQ-029 SHALL accept start on the first edge after Rst deasserts.

Structure
REQ-030 SHALL place the state enum, V_SIZE default and DW default in a shared package hht_pkg, shared with control.
REQ-031 SHALL implement the output register and valid/ready holding as one sub-module, hht_out_stage; FSM and address counters stay in the top level.

Verification
REQ-032 Basic run: v_base=2, col_base=340, csize=102, memory as in the existing HHT bench, col_ready=1 -> val = 78,59,60,62,1,35,40,43,63; col_data sequence starts 11,2,6,24 and ends 10,24; exactly 102 words; done pulses once, 9+102+2 cycles after start.
REQ-033 Backpressure: col_ready=0 for 5 cycles when j=3 -> col_data holds 24, mem_rd=0, no word lost or duplicated.
REQ-034 csize=0 -> LOAD_V for 9 cycles, then DONE; col_valid is never asserted.
REQ-035 Rst pulse at column 50 -> all outputs zero at once, no done; a following start runs a full clean run.
REQ-036 start held high throughout a run -> the run is not restarted; exactly one run plus one restart after DONE.
REQ-037 v_base=32'hFFFF_FFFC -> addresses wrap FFFF_FFFC..FFFF_FFFF, then 0..4.
